// File: rtl/action_mod_sequencer_pkg.sv
// Shared OpenFlow action definitions and small helpers for the action-modify sequencer.
package action_mod_sequencer_pkg;

  localparam int OPENFLOW_ACTION_WIDTH = 64;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/action_mod_sequencer.sv
// Read-modify-write sequencer: fetches an action-table entry, hands it to an external
// action modifier, writes the result back and reports completion/timeouts.
module action_mod_sequencer
  import action_mod_sequencer_pkg::*;
#(
  parameter int FLAG_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [OPENFLOW_ACTION_WIDTH-1:0] req_param,
  input  logic [FLAG_WIDTH-1:0]            req_flag,
  output logic                             tbl_rd_req,
  output logic [ADDR_WIDTH-1:0]            tbl_rd_addr,
  input  logic [OPENFLOW_ACTION_WIDTH-1:0] tbl_rd_data,
  input  logic                             tbl_rd_vld,
  output logic                             tbl_wr_req,
  output logic [ADDR_WIDTH-1:0]            tbl_wr_addr,
  output logic [OPENFLOW_ACTION_WIDTH-1:0] tbl_wr_data,
  input  logic                             tbl_wr_ack,
  output logic                             mod_enable,
  output logic [OPENFLOW_ACTION_WIDTH-1:0] mod_action_in,
  output logic [OPENFLOW_ACTION_WIDTH-1:0] mod_param,
  output logic [FLAG_WIDTH-1:0]            mod_flag,
  input  logic [OPENFLOW_ACTION_WIDTH-1:0] mod_action_out,
  input  logic                             mod_done,
  output logic                             cmpl_valid,
  output logic                             cmpl_error,
  output logic [ADDR_WIDTH-1:0]            cmpl_addr,
  output logic                             busy,
  output logic [7:0]                       err_count
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RD_WAIT,
    MODIFY,
    MOD_WAIT,
    WRITE,
    DONE
  } state_e;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                           state_q, state_d;
  logic                             armed_q;
  logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
  logic [OPENFLOW_ACTION_WIDTH-1:0] param_q, param_d;
  logic [FLAG_WIDTH-1:0]            flag_q, flag_d;
  logic [OPENFLOW_ACTION_WIDTH-1:0] rdat_q, rdat_d;
  logic [OPENFLOW_ACTION_WIDTH-1:0] mres_q, mres_d;
  logic [TW-1:0]                    timer_q, timer_d;
  logic                             err_q, err_d;
  logic [7:0]                       errcnt_q, errcnt_d;

  // armed_q keeps req_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      armed_q  <= 1'b0;
      addr_q   <= '0;
      param_q  <= '0;
      flag_q   <= '0;
      rdat_q   <= '0;
      mres_q   <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      addr_q   <= addr_d;
      param_q  <= param_d;
      flag_q   <= flag_d;
      rdat_q   <= rdat_d;
      mres_q   <= mres_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    param_d  = param_q;
    flag_d   = flag_q;
    rdat_d   = rdat_q;
    mres_d   = mres_q;
    timer_d  = timer_q;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && armed_q) begin
          addr_d  = req_addr;
          param_d = req_param;
          flag_d  = req_flag;
          err_d   = 1'b0;
          timer_d = '0;
          state_d = (req_flag == '0) ? DONE : READ;
        end
      end
      READ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (tbl_rd_vld) begin
          rdat_d  = tbl_rd_data;
          state_d = MODIFY;
        end
      end
      MODIFY: begin
        timer_d = '0;
        state_d = MOD_WAIT;
      end
      MOD_WAIT: begin
        if (mod_done) begin
          mres_d  = mod_action_out;
          state_d = WRITE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          errcnt_d = sat_inc8(errcnt_q);
          state_d  = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WRITE: begin
        if (tbl_wr_ack) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE) && armed_q;
    busy       = (state_q != IDLE);
    tbl_rd_req = (state_q == READ);
    mod_enable = (state_q == MODIFY);
    tbl_wr_req = (state_q == WRITE);
    cmpl_valid = (state_q == DONE);
    cmpl_error = (state_q == DONE) && err_q;
  end

  assign tbl_rd_addr   = addr_q;
  assign tbl_wr_addr   = addr_q;
  assign tbl_wr_data   = mres_q;
  assign mod_action_in = rdat_q;
  assign mod_param     = param_q;
  assign mod_flag      = flag_q;
  assign cmpl_addr     = addr_q;
  assign err_count     = errcnt_q;

endmodule
